// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: load-use, branch, mul/div and memory-wait stalls,
// operand forwarding selects, a mul/div occupancy tracker and a stall counter.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 8,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] DE_Rs,
  input  logic [REG_AW-1:0] DE_Rt,
  input  logic [REG_AW-1:0] DE_RDest,
  input  logic [REG_AW-1:0] EX_Rs,
  input  logic [REG_AW-1:0] EX_Rt,
  input  logic [REG_AW-1:0] EX_RDest,
  input  logic [REG_AW-1:0] ME_RDest,
  input  logic [REG_AW-1:0] WB_RDest,
  input  logic              DE_C_Branch,
  input  logic              DE_C_MultiCycle,
  input  logic              EX_C_Load,
  input  logic              EX_C_WriteReg,
  input  logic              ME_C_Load,
  input  logic              ME_C_WriteReg,
  input  logic              WB_C_WriteReg,
  input  logic              ME_C_MemReady,
  output logic              IF_C_StallPC,
  output logic              IF_C_StallOutput,
  output logic              DE_C_FlushOutput,
  output logic              EX_C_StallPipe,
  output logic [1:0]        DE_C_ForwardA,
  output logic [1:0]        DE_C_ForwardB,
  output logic [1:0]        EX_C_ForwardA,
  output logic [1:0]        EX_C_ForwardB,
  output logic              MD_C_Busy,
  output logic              MD_C_Done,
  output logic [REG_AW-1:0] MD_RDest,
  output logic [PERF_W-1:0] PerfStallCount
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  localparam logic [7:0] CountInit = 8'(MD_LAT - 1);

  md_state_e         state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [REG_AW-1:0] md_rdest_q, md_rdest_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic lw_stall, branch_stall, md_stall, mem_stall, hazard_stall, stall_any, md_issue;

  // Register 0 never produces a match.
  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (dst != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              md_done,
    input logic [REG_AW-1:0] md_rd,
    input logic              me_wr,
    input logic [REG_AW-1:0] me_rd,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_rd
  );
    if (md_done && hit(src, md_rd))      return 2'b11;
    else if (me_wr && hit(src, me_rd))   return 2'b10;
    else if (wb_wr && hit(src, wb_rd))   return 2'b01;
    else                                 return 2'b00;
  endfunction

  assign MD_C_Busy = (state_q != StIdle);
  assign MD_C_Done = (state_q == StDone);
  assign MD_RDest  = md_rdest_q;
  assign PerfStallCount = perf_q;

  assign lw_stall     = EX_C_Load & (hit(DE_Rs, EX_RDest) | hit(DE_Rt, EX_RDest));
  assign branch_stall = DE_C_Branch &
                        ((EX_C_WriteReg & (hit(DE_Rs, EX_RDest) | hit(DE_Rt, EX_RDest))) |
                         (ME_C_Load & (hit(DE_Rs, ME_RDest) | hit(DE_Rt, ME_RDest))));
  assign md_stall     = MD_C_Busy & ~MD_C_Done &
                        (hit(DE_Rs, md_rdest_q) | hit(DE_Rt, md_rdest_q) |
                         hit(DE_RDest, md_rdest_q) | DE_C_MultiCycle);
  assign mem_stall    = ~ME_C_MemReady;
  assign hazard_stall = lw_stall | branch_stall | md_stall;
  assign stall_any    = hazard_stall | mem_stall;
  assign md_issue     = DE_C_MultiCycle & ~stall_any;

  assign IF_C_StallPC     = stall_any;
  assign IF_C_StallOutput = stall_any;
  // A memory wait freezes the whole pipe, so a bubble must not be injected.
  assign DE_C_FlushOutput = hazard_stall & ~mem_stall;
  assign EX_C_StallPipe   = mem_stall;

  assign DE_C_ForwardA = fwd_sel(DE_Rs, MD_C_Done, md_rdest_q, ME_C_WriteReg, ME_RDest,
                                 WB_C_WriteReg, WB_RDest);
  assign DE_C_ForwardB = fwd_sel(DE_Rt, MD_C_Done, md_rdest_q, ME_C_WriteReg, ME_RDest,
                                 WB_C_WriteReg, WB_RDest);
  assign EX_C_ForwardA = fwd_sel(EX_Rs, MD_C_Done, md_rdest_q, ME_C_WriteReg, ME_RDest,
                                 WB_C_WriteReg, WB_RDest);
  assign EX_C_ForwardB = fwd_sel(EX_Rt, MD_C_Done, md_rdest_q, ME_C_WriteReg, ME_RDest,
                                 WB_C_WriteReg, WB_RDest);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    md_rdest_d = md_rdest_q;
    unique case (state_q)
      StIdle: begin
        if (md_issue) begin
          state_d    = StBusy;
          count_d    = CountInit;
          md_rdest_d = DE_RDest;
        end
      end
      StBusy: begin
        if (!mem_stall) begin
          if (count_q == 8'd1) state_d = StDone;
          else                 count_d = count_q - 8'd1;
        end
      end
      StDone: begin
        // Back-to-back issue: the next op can start as the result retires.
        if (!mem_stall) begin
          if (md_issue) begin
            state_d    = StBusy;
            count_d    = CountInit;
            md_rdest_d = DE_RDest;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (stall_any && (perf_q != '1)) perf_d = perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= 8'd0;
      md_rdest_q <= '0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      md_rdest_q <= md_rdest_d;
      perf_q     <= perf_d;
    end
  end

endmodule
